ex_mdu_stage: RTL and testbench
===============================

EX_MDU_STAGE -- requirements
Module: ex_mdu_stage

Interface
REQ-001 SHALL have ports i_clk in 1 (clock, rising edge); i_rst_n in 1 (reset, synchronous, active-low).
REQ-002 SHALL have ports i_alu_op in 8 (sub-op from decode) and i_alu_sel in 3 (op class from decode).
REQ-003 SHALL have ports i_op_reg_0 in 32, i_op_reg_1 in 32 (resolved operands) and i_reg_wen in 1, i_reg_waddr in 5 (GPR destination).
REQ-004 SHALL have ports i_hi in 32, i_lo in 32 (HI/LO register file values).
REQ-005 SHALL have ports i_mem_hilo_wen in 1, i_mem_hi in 32, i_mem_lo in 32, i_wb_hilo_wen in 1, i_wb_hi in 32, i_wb_lo in 32 (HI/LO forwarding).
REQ-006 SHALL have ports o_wen out 1, o_waddr out 5, o_wdata out 32 (GPR result; also the EX forwarding path into decode).
REQ-007 SHALL have ports o_hilo_wen out 1, o_hi out 32, o_lo out 32 (HI/LO write) and o_streq out 1 (stall request to pipeline control).

Function
REQ-008 SHALL compute LOGIC (OR/AND/XOR/NOR), SHIFT (SLL/SRL/SRA, amount = i_op_reg_0[4:0], value = i_op_reg_1), ARITHMETIC (ADD/ADDU/ADDI/ADDIU/SUB/SUBU/SLT/SLTU/CLZ/CLO) and MOVE results combinationally, with zero extra latency.
REQ-009 SHALL select o_wdata by i_alu_sel; NOP class gives o_wdata=0.
REQ-010 SHALL resolve effective HI/LO with priority MEM forward > WB forward > i_hi/i_lo; MFHI/MFLO return the effective value.
REQ-011 SHALL, for MTHI, assert o_hilo_wen with o_hi=i_op_reg_0, o_lo=effective LO; MTLO symmetric.
REQ-012 SHALL, for ADD/ADDI/SUB with signed overflow, force o_wen=0.
REQ-013 SHALL execute MULT, MULTU, MUL with an iterative radix-2 shift-add multiplier, FSM states IDLE, BUSY, DONE.
REQ-014 IDLE: on a multiply op, latch magnitudes of both operands (signed ops: two's-complement absolute value) and the sign flag, clear the 64-bit accumulator, load counter=0, go to BUSY; o_streq=1 that cycle.
REQ-015 BUSY: one partial-product step per cycle, counter increments; after step 31, go to DONE; o_streq=1 throughout.
REQ-016 DONE: drive the result (negated if sign flag set), o_streq=0, return to IDLE next cycle; total 34 cycles from issue to result, 33 stalled.
REQ-017 SHALL, in DONE, drive o_hilo_wen=1, o_hi=prod[63:32], o_lo=prod[31:0] for MULT/MULTU; o_wen=i_reg_wen, o_wdata=prod[31:0], o_hilo_wen=0 for MUL.
REQ-018 SHALL keep o_wen=0 and o_hilo_wen=0 during IDLE-issue and BUSY cycles of a multiply.
REQ-019 Upstream SHALL hold inputs stable while o_streq=1; the block SHALL use only latched operands in BUSY/DONE.
REQ-020 SHALL treat i_op_reg_x = 0x80000000 as magnitude 0x80000000 (33-bit-safe abs), giving correct MULT results.
REQ-021 SHALL pass o_waddr=i_reg_waddr unchanged in all states.

Reset
REQ-022 SHALL, on i_rst_n=0 at a clock edge, force FSM to IDLE, counter and accumulator to 0, including mid-BUSY abort.
REQ-023 SHALL drive o_wen=0, o_hilo_wen=0, o_wdata=0, o_hi=0, o_lo=0, o_streq=0 while i_rst_n=0.

Structure
REQ-024 ALU op/sel codes, HI/LO widths and mul FSM state enum SHALL live in the shared defines package.
REQ-025 The iterative multiplier SHALL be a sub-module mdu_mul (start, signed, a, b -> busy, done, prod[63:0]).

Verification
REQ-026 ADDU 0x00000005, 0xFFFFFFFF, waddr 3 -> same cycle o_wen=1, o_waddr=3, o_wdata=0x00000004, o_streq=0.
REQ-027 ADD 0x7FFFFFFF, 0x00000001 -> o_wen=0 (overflow); SLT 0xFFFFFFFF, 0x1 -> o_wdata=1; SLTU same -> 0.
REQ-028 MULT 0xFFFFFFFE, 0x00000003 -> o_streq=1 for 33 cycles, then o_hilo_wen=1, o_hi=0xFFFFFFFF, o_lo=0xFFFFFFFA.
REQ-029 MFHI with i_hi=0x11, i_wb_hi=0x22 (wb wen), i_mem_hi=0x33 (mem wen) -> 0x33; drop mem wen -> 0x22.
REQ-030 MULTU 0x80000000 x 0x2 with reset at BUSY cycle 10 -> o_streq=0 next cycle, FSM IDLE, no HI/LO write.
REQ-031 MUL 0x80000000 x 0xFFFFFFFF, waddr 7 -> after 34 cycles o_wen=1, o_wdata=0x80000000, o_hilo_wen=0.

Source files
------------

// File: rtl/ex_mdu_stage_pkg.sv
// Shared definitions for the EX-stage ALU/MDU: op-class and sub-op codes,
// HI/LO and product widths, multiplier FSM states and a count-leading-zeros helper.
package ex_mdu_stage_pkg;

  localparam int REG_W     = 32;
  localparam int HILO_W    = 32;
  localparam int PROD_W    = 64;
  localparam int MUL_STEPS = 32;

  // Operation class from decode (i_alu_sel)
  typedef enum logic [2:0] {
    SEL_NOP   = 3'b000,
    SEL_LOGIC = 3'b001,
    SEL_SHIFT = 3'b010,
    SEL_MOVE  = 3'b011,
    SEL_ARITH = 3'b100,
    SEL_MUL   = 3'b101
  } alu_sel_e;

  // Sub-operation codes from decode (i_alu_op)
  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_AND   = 8'h24;
  localparam logic [7:0] OP_OR    = 8'h25;
  localparam logic [7:0] OP_XOR   = 8'h26;
  localparam logic [7:0] OP_NOR   = 8'h27;
  localparam logic [7:0] OP_SLL   = 8'h7C;
  localparam logic [7:0] OP_SRL   = 8'h02;
  localparam logic [7:0] OP_SRA   = 8'h03;
  localparam logic [7:0] OP_MFHI  = 8'h10;
  localparam logic [7:0] OP_MTHI  = 8'h11;
  localparam logic [7:0] OP_MFLO  = 8'h12;
  localparam logic [7:0] OP_MTLO  = 8'h13;
  localparam logic [7:0] OP_ADD   = 8'h20;
  localparam logic [7:0] OP_ADDU  = 8'h21;
  localparam logic [7:0] OP_SUB   = 8'h22;
  localparam logic [7:0] OP_SUBU  = 8'h23;
  localparam logic [7:0] OP_SLT   = 8'h2A;
  localparam logic [7:0] OP_SLTU  = 8'h2B;
  localparam logic [7:0] OP_ADDI  = 8'h55;
  localparam logic [7:0] OP_ADDIU = 8'h56;
  localparam logic [7:0] OP_CLZ   = 8'hB0;
  localparam logic [7:0] OP_CLO   = 8'hB1;
  localparam logic [7:0] OP_MULT  = 8'h18;
  localparam logic [7:0] OP_MULTU = 8'h19;
  localparam logic [7:0] OP_MUL   = 8'hA9;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_BUSY = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_e;

  // Highest set bit wins because it is visited last; all-zero input yields 32.
  function automatic logic [5:0] clz32(input logic [31:0] v);
    logic [5:0] n;
    n = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) n = 6'(31 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/ex_mdu_stage_mul.sv
// Iterative radix-2 shift-add multiplier: sign-magnitude operands, one partial
// product per cycle over 32 BUSY cycles, result held for one DONE cycle.
module mdu_mul
  import ex_mdu_stage_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_signed,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_busy,
  output logic        o_done,
  output logic [63:0] o_prod
);

  mul_state_e          r_state;
  mul_state_e          w_state_nxt;
  logic [PROD_W-1:0]   r_mcand;
  logic [PROD_W-1:0]   r_acc;
  logic [REG_W-1:0]    r_mplier;
  logic [4:0]          r_cnt;
  logic                r_neg;

  logic                w_neg_a;
  logic                w_neg_b;
  logic [REG_W-1:0]    w_mag_a;
  logic [REG_W-1:0]    w_mag_b;

  // Negating 0x80000000 in 32 bits gives 0x80000000, which read unsigned is
  // exactly the magnitude we want, so no 33rd bit is needed.
  assign w_neg_a = i_signed & i_a[31];
  assign w_neg_b = i_signed & i_b[31];
  assign w_mag_a = w_neg_a ? (~i_a + 32'd1) : i_a;
  assign w_mag_b = w_neg_b ? (~i_b + 32'd1) : i_b;

  // NOTE: every signal written in an always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      MUL_IDLE: if (i_start) w_state_nxt = MUL_BUSY;
      MUL_BUSY: begin
        o_busy = 1'b1;
        if (r_cnt == 5'(MUL_STEPS - 1)) w_state_nxt = MUL_DONE;
      end
      MUL_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = MUL_IDLE;
      end
      default: w_state_nxt = MUL_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= MUL_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_neg    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        MUL_IDLE: begin
          if (i_start) begin
            r_mcand  <= {32'd0, w_mag_a};
            r_mplier <= w_mag_b;
            r_neg    <= w_neg_a ^ w_neg_b;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        MUL_BUSY: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_prod = r_neg ? (~r_acc + 64'd1) : r_acc;

endmodule

// File: rtl/ex_mdu_stage.sv
// EX stage: single-cycle logic/shift/arith/move results plus HI/LO handling,
// with MULT/MULTU/MUL routed through the iterative multiplier under a stall.
module ex_mdu_stage
  import ex_mdu_stage_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_alu_op,
  input  logic [2:0]  i_alu_sel,
  input  logic [31:0] i_op_reg_0,
  input  logic [31:0] i_op_reg_1,
  input  logic        i_reg_wen,
  input  logic [4:0]  i_reg_waddr,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  input  logic        i_mem_hilo_wen,
  input  logic [31:0] i_mem_hi,
  input  logic [31:0] i_mem_lo,
  input  logic        i_wb_hilo_wen,
  input  logic [31:0] i_wb_hi,
  input  logic [31:0] i_wb_lo,
  output logic        o_wen,
  output logic [4:0]  o_waddr,
  output logic [31:0] o_wdata,
  output logic        o_hilo_wen,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_streq
);

  logic [HILO_W-1:0] w_eff_hi;
  logic [HILO_W-1:0] w_eff_lo;
  logic [REG_W-1:0]  w_logic;
  logic [REG_W-1:0]  w_shift;
  logic [REG_W-1:0]  w_arith;
  logic [REG_W-1:0]  w_move;
  logic [REG_W-1:0]  w_sum;
  logic [REG_W-1:0]  w_diff;
  logic [4:0]        w_shamt;
  logic              w_ov_add;
  logic              w_ov_sub;
  logic              w_ov;
  logic              w_is_mul;
  logic              w_mul_signed;
  logic              w_mul_busy;
  logic              w_mul_done;
  logic [PROD_W-1:0] w_prod;

  // The youngest in-flight HI/LO write wins.
  assign w_eff_hi = i_mem_hilo_wen ? i_mem_hi : (i_wb_hilo_wen ? i_wb_hi : i_hi);
  assign w_eff_lo = i_mem_hilo_wen ? i_mem_lo : (i_wb_hilo_wen ? i_wb_lo : i_lo);

  always_comb begin
    w_logic = '0;
    case (i_alu_op)
      OP_OR:   w_logic = i_op_reg_0 | i_op_reg_1;
      OP_AND:  w_logic = i_op_reg_0 & i_op_reg_1;
      OP_XOR:  w_logic = i_op_reg_0 ^ i_op_reg_1;
      OP_NOR:  w_logic = ~(i_op_reg_0 | i_op_reg_1);
      default: w_logic = '0;
    endcase
  end

  assign w_shamt = i_op_reg_0[4:0];

  always_comb begin
    w_shift = '0;
    case (i_alu_op)
      OP_SLL:  w_shift = i_op_reg_1 << w_shamt;
      OP_SRL:  w_shift = i_op_reg_1 >> w_shamt;
      OP_SRA:  w_shift = $signed(i_op_reg_1) >>> w_shamt;
      default: w_shift = '0;
    endcase
  end

  // Signed overflow: operands agree in sign (add) or differ (sub) and the
  // result sign departs from operand 0.
  assign w_sum    = i_op_reg_0 + i_op_reg_1;
  assign w_diff   = i_op_reg_0 - i_op_reg_1;
  assign w_ov_add = (i_op_reg_0[31] == i_op_reg_1[31]) && (w_sum[31] != i_op_reg_0[31]);
  assign w_ov_sub = (i_op_reg_0[31] != i_op_reg_1[31]) && (w_diff[31] != i_op_reg_0[31]);
  assign w_ov     = (((i_alu_op == OP_ADD) || (i_alu_op == OP_ADDI)) && w_ov_add) ||
                    ((i_alu_op == OP_SUB) && w_ov_sub);

  always_comb begin
    w_arith = '0;
    case (i_alu_op)
      OP_ADD, OP_ADDU, OP_ADDI, OP_ADDIU: w_arith = w_sum;
      OP_SUB, OP_SUBU:                    w_arith = w_diff;
      OP_SLT:  w_arith = {31'd0, $signed(i_op_reg_0) < $signed(i_op_reg_1)};
      OP_SLTU: w_arith = {31'd0, i_op_reg_0 < i_op_reg_1};
      OP_CLZ:  w_arith = {26'd0, clz32(i_op_reg_0)};
      OP_CLO:  w_arith = {26'd0, clz32(~i_op_reg_0)};
      default: w_arith = '0;
    endcase
  end

  always_comb begin
    w_move = '0;
    case (i_alu_op)
      OP_MFHI: w_move = w_eff_hi;
      OP_MFLO: w_move = w_eff_lo;
      default: w_move = '0;
    endcase
  end

  assign w_is_mul     = (i_alu_op == OP_MULT) || (i_alu_op == OP_MULTU) || (i_alu_op == OP_MUL);
  assign w_mul_signed = (i_alu_op != OP_MULTU);

  // Start is only honoured in IDLE, so holding the op through BUSY/DONE is safe.
  mdu_mul u_mul (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (w_is_mul),
    .i_signed (w_mul_signed),
    .i_a      (i_op_reg_0),
    .i_b      (i_op_reg_1),
    .o_busy   (w_mul_busy),
    .o_done   (w_mul_done),
    .o_prod   (w_prod)
  );

  always_comb begin
    o_wen      = 1'b0;
    o_wdata    = '0;
    o_hilo_wen = 1'b0;
    o_hi       = '0;
    o_lo       = '0;
    o_streq    = 1'b0;
    if (w_is_mul) begin
      // Stall on the issue cycle (multiplier idle) and all BUSY cycles.
      o_streq = w_mul_busy | ~(w_mul_busy | w_mul_done);
      if (w_mul_done) begin
        if (i_alu_op == OP_MUL) begin
          o_wen   = i_reg_wen;
          o_wdata = w_prod[31:0];
        end else begin
          o_hilo_wen = 1'b1;
          o_hi       = w_prod[63:32];
          o_lo       = w_prod[31:0];
        end
      end
    end else begin
      o_wen = i_reg_wen & ~w_ov;
      case (i_alu_sel)
        SEL_LOGIC: o_wdata = w_logic;
        SEL_SHIFT: o_wdata = w_shift;
        SEL_ARITH: o_wdata = w_arith;
        SEL_MOVE:  o_wdata = w_move;
        default:   o_wdata = '0;
      endcase
      if (i_alu_op == OP_MTHI) begin
        o_hilo_wen = 1'b1;
        o_hi       = i_op_reg_0;
        o_lo       = w_eff_lo;
      end else if (i_alu_op == OP_MTLO) begin
        o_hilo_wen = 1'b1;
        o_hi       = w_eff_hi;
        o_lo       = i_op_reg_0;
      end
    end
    if (!i_rst_n) begin
      o_wen      = 1'b0;
      o_wdata    = '0;
      o_hilo_wen = 1'b0;
      o_hi       = '0;
      o_lo       = '0;
      o_streq    = 1'b0;
    end
  end

  assign o_waddr = i_reg_waddr;

endmodule

// File: tb/tb_ex_mdu_stage.sv
// Self-checking bench for ex_mdu_stage: behavioural model compared every cycle,
// directed literal cases, then randomized single-cycle ops and multiplies.
module tb_ex_mdu_stage;
  import ex_mdu_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  alu_op = 8'h00;
  logic [2:0]  alu_sel = 3'd0;
  logic [31:0] op_a = '0, op_b = '0;
  logic        reg_wen = 1'b0;
  logic [4:0]  reg_waddr = '0;
  logic [31:0] hi = '0, lo = '0;
  logic        mem_hilo_wen = 1'b0, wb_hilo_wen = 1'b0;
  logic [31:0] mem_hi = '0, mem_lo = '0, wb_hi = '0, wb_lo = '0;

  // Forwarding values applied by the next drive()
  logic [31:0] n_hi = '0, n_lo = '0, n_mem_hi = '0, n_mem_lo = '0, n_wb_hi = '0, n_wb_lo = '0;
  logic        n_mem_wen = 1'b0, n_wb_wen = 1'b0;

  logic        o_wen, o_hilo_wen, o_streq;
  logic [4:0]  o_waddr;
  logic [31:0] o_wdata, o_hi, o_lo;

  int n_checks = 0;
  int n_errors = 0;
  int mul_age  = 0;

  typedef struct packed {
    logic        wen;
    logic [31:0] wdata;
    logic        hilo_wen;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        e_exp;
  logic [63:0] p_exp;

  always #5 clk = ~clk;

  ex_mdu_stage dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_alu_op       (alu_op),
    .i_alu_sel      (alu_sel),
    .i_op_reg_0     (op_a),
    .i_op_reg_1     (op_b),
    .i_reg_wen      (reg_wen),
    .i_reg_waddr    (reg_waddr),
    .i_hi           (hi),
    .i_lo           (lo),
    .i_mem_hilo_wen (mem_hilo_wen),
    .i_mem_hi       (mem_hi),
    .i_mem_lo       (mem_lo),
    .i_wb_hilo_wen  (wb_hilo_wen),
    .i_wb_hi        (wb_hi),
    .i_wb_lo        (wb_lo),
    .o_wen          (o_wen),
    .o_waddr        (o_waddr),
    .o_wdata        (o_wdata),
    .o_hilo_wen     (o_hilo_wen),
    .o_hi           (o_hi),
    .o_lo           (o_lo),
    .o_streq        (o_streq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_mul(input logic [7:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MUL);
  endfunction

  function automatic logic [31:0] lead_count(input logic [31:0] v);
    int k = 31;
    while (k >= 0 && v[k] == 1'b0) k--;
    return 32'(31 - k);
  endfunction

  // Reference for all single-cycle ops, from plain signed/unsigned arithmetic.
  function automatic exp_t model_comb();
    exp_t        e;
    longint      sa, sb, s;
    logic [31:0] ehi, elo, res;
    logic        ov;
    sa  = longint'($signed(op_a));
    sb  = longint'($signed(op_b));
    ehi = mem_hilo_wen ? mem_hi : (wb_hilo_wen ? wb_hi : hi);
    elo = mem_hilo_wen ? mem_lo : (wb_hilo_wen ? wb_lo : lo);
    res = '0;
    ov  = 1'b0;
    s   = 0;
    case (alu_sel)
      SEL_LOGIC: case (alu_op)
        OP_OR:  res = op_a | op_b;
        OP_AND: res = op_a & op_b;
        OP_XOR: res = op_a ^ op_b;
        OP_NOR: res = ~(op_a | op_b);
        default: res = '0;
      endcase
      SEL_SHIFT: case (alu_op)
        OP_SLL: res = op_b << op_a[4:0];
        OP_SRL: res = op_b >> op_a[4:0];
        OP_SRA: res = 32'(int'(op_b) >>> op_a[4:0]);
        default: res = '0;
      endcase
      SEL_ARITH: case (alu_op)
        OP_ADD, OP_ADDU, OP_ADDI, OP_ADDIU: begin
          s   = sa + sb;
          res = s[31:0];
          ov  = (alu_op == OP_ADD || alu_op == OP_ADDI) &&
                (s > 64'sd2147483647 || s < -64'sd2147483648);
        end
        OP_SUB, OP_SUBU: begin
          s   = sa - sb;
          res = s[31:0];
          ov  = (alu_op == OP_SUB) && (s > 64'sd2147483647 || s < -64'sd2147483648);
        end
        OP_SLT:  res = (sa < sb) ? 32'd1 : 32'd0;
        OP_SLTU: res = (op_a < op_b) ? 32'd1 : 32'd0;
        OP_CLZ:  res = lead_count(op_a);
        OP_CLO:  res = lead_count(~op_a);
        default: res = '0;
      endcase
      SEL_MOVE: case (alu_op)
        OP_MFHI: res = ehi;
        OP_MFLO: res = elo;
        default: res = '0;
      endcase
      default: res = '0;
    endcase
    e.wen      = reg_wen && !ov;
    e.wdata    = res;
    e.hilo_wen = 1'b0;
    e.hi       = '0;
    e.lo       = '0;
    if (alu_op == OP_MTHI) begin
      e.hilo_wen = 1'b1; e.hi = op_a; e.lo = elo;
    end else if (alu_op == OP_MTLO) begin
      e.hilo_wen = 1'b1; e.hi = ehi; e.lo = op_a;
    end
    return e;
  endfunction

  // Cycles since a multiply was issued: result appears on the 34th cycle.
  always @(posedge clk) begin
    if (!rst_n)               mul_age <= 0;
    else if (is_mul(alu_op))  mul_age <= (mul_age == 33) ? 0 : mul_age + 1;
    else                      mul_age <= 0;
  end

  always @(negedge clk) begin
    check("waddr", {27'd0, o_waddr}, {27'd0, reg_waddr});
    if (!rst_n) begin
      check("rst_streq", {31'd0, o_streq}, 32'd0);
      check("rst_wen", {31'd0, o_wen}, 32'd0);
      check("rst_hilo_wen", {31'd0, o_hilo_wen}, 32'd0);
      check("rst_wdata", o_wdata, 32'd0);
      check("rst_hi", o_hi, 32'd0);
      check("rst_lo", o_lo, 32'd0);
    end else if (is_mul(alu_op)) begin
      if (mul_age < 33) begin
        check("mul_stall", {31'd0, o_streq}, 32'd1);
        check("mul_stall_wen", {31'd0, o_wen}, 32'd0);
        check("mul_stall_hilo_wen", {31'd0, o_hilo_wen}, 32'd0);
      end else begin
        p_exp = (alu_op == OP_MULTU) ? ({32'd0, op_a} * {32'd0, op_b})
                                     : 64'(longint'($signed(op_a)) * longint'($signed(op_b)));
        check("mul_done_streq", {31'd0, o_streq}, 32'd0);
        if (alu_op == OP_MUL) begin
          check("mul_wen", {31'd0, o_wen}, {31'd0, reg_wen});
          check("mul_wdata", o_wdata, p_exp[31:0]);
          check("mul_hilo_wen", {31'd0, o_hilo_wen}, 32'd0);
        end else begin
          check("mult_wen", {31'd0, o_wen}, 32'd0);
          check("mult_hilo_wen", {31'd0, o_hilo_wen}, 32'd1);
          check("mult_hi", o_hi, p_exp[63:32]);
          check("mult_lo", o_lo, p_exp[31:0]);
        end
      end
    end else begin
      e_exp = model_comb();
      check("streq", {31'd0, o_streq}, 32'd0);
      check("wen", {31'd0, o_wen}, {31'd0, e_exp.wen});
      check("wdata", o_wdata, e_exp.wdata);
      check("hilo_wen", {31'd0, o_hilo_wen}, {31'd0, e_exp.hilo_wen});
      if (e_exp.hilo_wen) begin
        check("hi", o_hi, e_exp.hi);
        check("lo", o_lo, e_exp.lo);
      end
    end
  end

  // Apply one op after the edge, then return at the sampling point of that cycle.
  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic wen, input logic [4:0] wa);
    @(posedge clk);
    #1;
    alu_op = op; alu_sel = sel; op_a = a; op_b = b; reg_wen = wen; reg_waddr = wa;
    hi = n_hi; lo = n_lo;
    mem_hilo_wen = n_mem_wen; mem_hi = n_mem_hi; mem_lo = n_mem_lo;
    wb_hilo_wen = n_wb_wen; wb_hi = n_wb_hi; wb_lo = n_wb_lo;
    @(negedge clk);
  endtask

  // Issue a multiply, hold it, and return at the sampling point of the result cycle.
  task automatic run_mul(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic wen, input logic [4:0] wa);
    int stalls;
    drive(op, SEL_MUL, a, b, wen, wa);
    stalls = 0;
    while (o_streq === 1'b1 && stalls < 40) begin
      stalls++;
      @(posedge clk);
      @(negedge clk);
    end
    check("mul_stall_cycles", 32'(stalls), 32'd33);
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic pick_comb(input int idx, output logic [7:0] op, output logic [2:0] sel);
    case (idx)
      0:  begin op = OP_OR;    sel = SEL_LOGIC; end
      1:  begin op = OP_AND;   sel = SEL_LOGIC; end
      2:  begin op = OP_XOR;   sel = SEL_LOGIC; end
      3:  begin op = OP_NOR;   sel = SEL_LOGIC; end
      4:  begin op = OP_SLL;   sel = SEL_SHIFT; end
      5:  begin op = OP_SRL;   sel = SEL_SHIFT; end
      6:  begin op = OP_SRA;   sel = SEL_SHIFT; end
      7:  begin op = OP_ADD;   sel = SEL_ARITH; end
      8:  begin op = OP_ADDU;  sel = SEL_ARITH; end
      9:  begin op = OP_ADDI;  sel = SEL_ARITH; end
      10: begin op = OP_ADDIU; sel = SEL_ARITH; end
      11: begin op = OP_SUB;   sel = SEL_ARITH; end
      12: begin op = OP_SUBU;  sel = SEL_ARITH; end
      13: begin op = OP_SLT;   sel = SEL_ARITH; end
      14: begin op = OP_SLTU;  sel = SEL_ARITH; end
      15: begin op = OP_CLZ;   sel = SEL_ARITH; end
      16: begin op = OP_CLO;   sel = SEL_ARITH; end
      17: begin op = OP_MFHI;  sel = SEL_MOVE;  end
      18: begin op = OP_MFLO;  sel = SEL_MOVE;  end
      19: begin op = OP_MTHI;  sel = SEL_MOVE;  end
      20: begin op = OP_MTLO;  sel = SEL_MOVE;  end
      default: begin op = OP_NOP; sel = SEL_NOP; end
    endcase
  endtask

  initial begin
    logic [7:0] r_op;
    logic [2:0] r_sel;
    logic [7:0] m_op;

    // Reset with a live op on the inputs: outputs must still be zero.
    alu_op = OP_ADDU; alu_sel = SEL_ARITH; op_a = 32'h1234; op_b = 32'h1; reg_wen = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("lit_rst_wdata", o_wdata, 32'd0);
    check("lit_rst_wen", {31'd0, o_wen}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    drive(OP_ADDU, SEL_ARITH, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 5'd3);
    check("lit_addu_wen", {31'd0, o_wen}, 32'd1);
    check("lit_addu_waddr", {27'd0, o_waddr}, 32'd3);
    check("lit_addu_wdata", o_wdata, 32'h0000_0004);
    check("lit_addu_streq", {31'd0, o_streq}, 32'd0);

    drive(OP_ADD, SEL_ARITH, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 5'd4);
    check("lit_add_ovf_wen", {31'd0, o_wen}, 32'd0);
    drive(OP_SLT, SEL_ARITH, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 5'd5);
    check("lit_slt", o_wdata, 32'd1);
    drive(OP_SLTU, SEL_ARITH, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 5'd5);
    check("lit_sltu", o_wdata, 32'd0);
    drive(OP_CLZ, SEL_ARITH, 32'h0001_0000, 32'h0, 1'b1, 5'd6);
    check("lit_clz", o_wdata, 32'd15);

    n_hi = 32'h11; n_wb_wen = 1'b1; n_wb_hi = 32'h22; n_mem_wen = 1'b1; n_mem_hi = 32'h33;
    drive(OP_MFHI, SEL_MOVE, 32'h0, 32'h0, 1'b1, 5'd8);
    check("lit_mfhi_mem", o_wdata, 32'h33);
    n_mem_wen = 1'b0;
    drive(OP_MFHI, SEL_MOVE, 32'h0, 32'h0, 1'b1, 5'd8);
    check("lit_mfhi_wb", o_wdata, 32'h22);
    n_hi = '0; n_wb_wen = 1'b0; n_wb_hi = '0; n_mem_hi = '0;

    run_mul(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 5'd0);
    check("lit_mult_hilo_wen", {31'd0, o_hilo_wen}, 32'd1);
    check("lit_mult_hi", o_hi, 32'hFFFF_FFFF);
    check("lit_mult_lo", o_lo, 32'hFFFF_FFFA);
    check("lit_mult_streq", {31'd0, o_streq}, 32'd0);

    // MULTU aborted by reset in BUSY cycle 10
    drive(OP_MULTU, SEL_MUL, 32'h8000_0000, 32'h0000_0002, 1'b0, 5'd0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0; alu_op = OP_NOP; alu_sel = SEL_NOP;
    @(negedge clk);
    check("lit_abort_rst_streq", {31'd0, o_streq}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("lit_abort_streq", {31'd0, o_streq}, 32'd0);
    check("lit_abort_hilo_wen", {31'd0, o_hilo_wen}, 32'd0);
    // A fresh multiply after the abort must take the full latency again.
    run_mul(OP_MULTU, 32'h8000_0000, 32'h0000_0002, 1'b0, 5'd0);
    check("lit_multu_hi", o_hi, 32'h0000_0001);
    check("lit_multu_lo", o_lo, 32'h0000_0000);

    run_mul(OP_MUL, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 5'd7);
    check("lit_mul_wen", {31'd0, o_wen}, 32'd1);
    check("lit_mul_waddr", {27'd0, o_waddr}, 32'd7);
    check("lit_mul_wdata", o_wdata, 32'h8000_0000);
    check("lit_mul_hilo_wen", {31'd0, o_hilo_wen}, 32'd0);

    for (int i = 0; i < 400; i++) begin
      n_hi = $urandom; n_lo = $urandom;
      n_mem_wen = 1'($urandom_range(0, 1)); n_mem_hi = $urandom; n_mem_lo = $urandom;
      n_wb_wen = 1'($urandom_range(0, 1));  n_wb_hi = $urandom;  n_wb_lo = $urandom;
      if (i % 40 == 39) begin
        case ($urandom_range(0, 2))
          0:       m_op = OP_MULT;
          1:       m_op = OP_MULTU;
          default: m_op = OP_MUL;
        endcase
        run_mul(m_op, rnd32(), rnd32(), 1'($urandom_range(0, 1)), 5'($urandom));
      end else begin
        pick_comb($urandom_range(0, 21), r_op, r_sel);
        drive(r_op, r_sel, rnd32(), rnd32(), 1'($urandom_range(0, 1)), 5'($urandom));
      end
    end

    drive(OP_NOP, SEL_NOP, 32'h0, 32'h0, 1'b0, 5'd0);
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
